// File: rtl/mac_pipe_if.sv
// mac_pipe_if: operand/control input and result output handshake bundle for mac_pipe
interface mac_pipe_if #(
  parameter int W = 4,
  parameter int ACC_EXTRA = 4
);
  logic signed [W-1:0] in0;
  logic signed [W-1:0] in1;
  logic mode;
  logic clr_acc;
  logic in_valid;
  logic in_ready;
  logic signed [2*W+ACC_EXTRA-1:0] out0;
  logic out_valid;
  logic out_ready;
  logic overflow;
  modport master (
    output in0, in1, mode, clr_acc, in_valid, out_ready,
    input  in_ready, out0, out_valid, overflow
  );
  modport slave (
    input  in0, in1, mode, clr_acc, in_valid, out_ready,
    output in_ready, out0, out_valid, overflow
  );
endinterface

// File: rtl/mac_pipe.sv
// mac_pipe: two-stage signed multiply / multiply-accumulate with valid/ready backpressure
module mac_pipe #(
  parameter int W = 4,
  parameter int ACC_EXTRA = 4
) (
  input logic clk,
  input logic reset,
  mac_pipe_if.slave bus
);
  localparam int OW = 2*W + ACC_EXTRA;
  logic signed [2*W-1:0] p1_q, p1_d;
  logic v1_q, v1_d, m1_q, m1_d, c1_q, c1_d;
  logic signed [OW-1:0] acc_q, acc_d, out0_q, out0_d;
  logic out_valid_q, out_valid_d, ovf_q, ovf_d;
  logic en, wr_acc, ovf;
  logic signed [OW-1:0] prod_x, base, sum;
  assign en = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en;
  assign bus.out0 = out0_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overflow = ovf_q;
  // Next state: the whole pipeline advances together only when the output slot can move
  always_comb begin
    prod_x = OW'(p1_q);
    base = c1_q ? '0 : acc_q;
    sum = base + prod_x;
    ovf = (base[OW-1] == prod_x[OW-1]) && (sum[OW-1] != base[OW-1]);
    wr_acc = en && v1_q && m1_q;
    p1_d = en ? bus.in0 * bus.in1 : p1_q;
    v1_d = en ? bus.in_valid : v1_q;
    m1_d = en ? bus.mode : m1_q;
    c1_d = en ? bus.clr_acc : c1_q;
    out_valid_d = en ? v1_q : out_valid_q;
    out0_d = (en && v1_q) ? (m1_q ? sum : prod_x) : out0_q;
    acc_d = wr_acc ? sum : acc_q;
    ovf_d = wr_acc ? ((!c1_q && ovf_q) || ovf) : ovf_q;
  end
  // State registers; reset drops in-flight samples and clears the running sum
  always_ff @(posedge clk) begin
    if (reset) begin
      p1_q <= '0;
      v1_q <= 1'b0;
      m1_q <= 1'b0;
      c1_q <= 1'b0;
      out_valid_q <= 1'b0;
      out0_q <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      p1_q <= p1_d;
      v1_q <= v1_d;
      m1_q <= m1_d;
      c1_q <= c1_d;
      out_valid_q <= out_valid_d;
      out0_q <= out0_d;
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: doc/mac_pipe.md
Name: mac_pipe

Overview:
Parametrised, pipelined signed multiplier / multiply-accumulate unit with valid/ready handshakes on input and output. It is the sequential successor to the team's small combinational signed multiplier. It sits between IO/datapath producers and consumers that need either plain products or running sums of products, with backpressure support. Two selectable modes: plain multiply (mode=0) and accumulate (mode=1).

Parameters:
W, 4, signed operand width (W >= 2)
ACC_EXTRA, 4, accumulator guard bits (>= 0); result width OW = 2*W + ACC_EXTRA

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
in0  input  W  signed operand A
in1  input  W  signed operand B
mode  input  1  0 = multiply, 1 = accumulate; sampled with the operands
clr_acc  input  1  with mode=1: start new sum (acc treated as 0 for this sample); ignored when mode=0
in_valid  input  1  operand/control set valid
in_ready  output  1  unit can accept this cycle
out0  output  OW  signed result
out_valid  output  1  out0 valid
out_ready  input  1  consumer accepts out0
overflow  output  1  sticky signed-overflow flag for the current accumulation

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Global enable: en = !out_valid || out_ready. in_ready = en (combinational).
- Input handshake: a transfer occurs when in_valid && in_ready. When en=0, the whole pipeline holds and no register changes.
- Stage 1 (when en):
  - p1 <= in0*in1, full signed 2W bits.
  - v1 <= in_valid.
  - m1 <= mode; c1 <= clr_acc.
- Stage 2 (when en):
  - out_valid <= v1.
  - If v1 && m1=0: out0 <= sign-extended p1. acc and overflow are unchanged.
  - If v1 && m1=1: sum = (c1 ? 0 : acc) + sext(p1), computed modulo 2^OW (wraps).
    - acc <= sum; out0 <= sum.
    - overflow <= (c1 ? 0 : overflow) | ovf, where ovf = addends share a sign and sum's sign differs.
  - If v1=0: out0, acc and overflow hold.
- Latency: 2 cycles from input transfer to out_valid when unstalled. Throughput: 1 sample per cycle.
- Backpressure: while out_valid && !out_ready, out0 and out_valid are held stable, in_ready=0, and acc is not updated. No sample is lost or duplicated across a stall.
- Output handshake: a transfer occurs when out_valid && out_ready.
- Modes may interleave freely. A mode=0 sample never disturbs acc or overflow.
- Reset: when reset=1 at a clock edge, v1, out_valid, acc, overflow, out0 and p1 all become 0, and in-flight samples are discarded.
  - Inputs presented during a reset cycle are not accepted.
  - The first cycle after reset has in_ready=1.
- Reset overrides every simultaneous event.

Test Plan:
(W=4, ACC_EXTRA=4, OW=12; out_ready=1 unless stated)
1. Multiply: mode=0, in0=-8, in1=7 accepted at cycle 0 -> out_valid=1 at cycle 2, out0=-56 (12'hFC8), overflow=0. Also in0=-8, in1=-8 -> out0=64.
2. Streaming: mode=0, pairs (1,1),(2,-3),(-4,5),(7,7) on consecutive cycles -> outputs 1, -6, -20, 49 on 4 consecutive cycles; in_ready stays 1.
3. Accumulate: mode=1 with clr_acc=1 on first sample only, pairs (3,5),(-2,4),(7,7) -> outputs 15, 7, 56. A following mode=0 (2,2) -> 4; then mode=1 (1,1) -> 57.
4. Overflow: mode=1, clr_acc on first, 32 samples of (-8,-8):
   - 31st output = 1984; 32nd = -2048 with overflow=1.
   - 33rd (1,1) without clr -> -2047, overflow stays 1.
   - Then (1,1) with clr -> 1, overflow=0.
5. Backpressure: hold out_ready=0 for 3 cycles while out_valid=1 with 2 samples in flight -> out0 stable, in_ready=0, acc unchanged. Release -> all samples appear in order exactly once; accumulated values are correct.
6. Reset mid-operation: assert reset for 1 cycle with 2 accumulate samples in flight and overflow=1 -> next cycle out_valid=0, overflow=0, in_ready=1. Then mode=1 (2,3) without clr -> out0=6, since acc was reset to 0.
